mem_ext_sequencer: RTL and testbench

- Initiator for the CPU's external memory ports; the CPU core is the responder.
- Streams a program into instruction memory and runs the CPU for a fixed cycle budget.
- Then reads back a window of data memory and streams it out.
- Sits beside cpu at top level; replaces testbench-driven addr_ext/wen_ext/enable sequencing.

---
 rtl/mem_ext_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_mem_ext_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ext_sequencer.sv
// mem_ext_sequencer
// Drives the CPU's external memory ports: streams a program into instruction
// memory, enables the CPU for a fixed number of cycles, then reads a window of
// data memory back and streams it out.
//
// Ports
//   clk, arst                 clock and asynchronous active-high reset
//   start                     one-cycle pulse, honoured only in IDLE or DONE
//   prog_len/run_cycles/dump_len  job lengths, latched on an accepted start
//   s_valid/s_ready/s_data    program word stream in (32-bit)
//   cpu_enable                CPU run enable
//   addr_ext/wen_ext/ren_ext/wdata_ext          imem port (write only)
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2  dmem port (read only)
//   rdata_ext_2               dmem read data, valid the cycle after ren_ext_2
//   m_valid/m_ready/m_data    dump word stream out (64-bit)
//   busy/done/error           status; error is meaningful while done is high
//   dbg_state_o               current FSM state
//
// Handshakes (both streams): a word transfers on a rising clk edge where
// valid && ready are both high. valid never depends on ready; once m_valid
// is raised, m_valid and m_data stay stable until that transfer.
module mem_ext_sequencer #(
  parameter int IMEM_DEPTH = 128,
  parameter int DMEM_DEPTH = 128
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        start,
  input  logic [15:0] prog_len,
  input  logic [31:0] run_cycles,
  input  logic [15:0] dump_len,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        cpu_enable,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [31:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] RUN      = 3'd2;
  localparam logic [2:0] DUMP_RD  = 3'd3;
  localparam logic [2:0] DUMP_CAP = 3'd4;
  localparam logic [2:0] DUMP_OUT = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [16:0] IMEM_LIM = 17'(IMEM_DEPTH);
  localparam logic [16:0] DMEM_LIM = 17'(DMEM_DEPTH);

  logic [2:0]  state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] pl_q, pl_d;
  logic [31:0] rc_q, rc_d;
  logic [15:0] dl_q, dl_d;
  logic [31:0] cnt_q, cnt_d;
  logic        cpu_en_q, cpu_en_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [63:0] addr2_q, addr2_d;
  logic        ren2_q, ren2_d;
  logic        m_valid_q, m_valid_d;
  logic [63:0] m_data_q, m_data_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  // "enter" picks the first non-empty phase after the current one; rc_sel and
  // dl_sel say which run/dump lengths apply (live inputs on start, latched
  // values afterwards, zero run once RUN has finished).
  logic        enter;
  logic [31:0] rc_sel;
  logic [15:0] dl_sel;
  logic [15:0] idx_inc;

  assign idx_inc = idx_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pl_d      = pl_q;
    rc_d      = rc_q;
    dl_d      = dl_q;
    cnt_d     = cnt_q;
    cpu_en_d  = 1'b0;
    addr_d    = addr_q;
    wen_d     = 1'b0;
    wdata_d   = wdata_q;
    addr2_d   = addr2_q;
    ren2_d    = 1'b0;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    done_d    = done_q;
    error_d   = error_q;
    enter     = 1'b0;
    rc_sel    = rc_q;
    dl_sel    = dl_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pl_d    = prog_len;
          rc_d    = run_cycles;
          dl_d    = dump_len;
          idx_d   = 16'd0;
          done_d  = 1'b0;
          error_d = 1'b0;
          if (({1'b0, prog_len} > IMEM_LIM) || ({1'b0, dump_len} > DMEM_LIM)) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (prog_len != 16'd0) begin
            state_d = LOAD;
          end else begin
            enter  = 1'b1;
            rc_sel = run_cycles;
            dl_sel = dump_len;
          end
        end
      end
      LOAD: begin
        if (s_valid) begin
          wen_d   = 1'b1;
          addr_d  = 64'(idx_q) << 2;
          wdata_d = s_data;
          if (idx_q == pl_q - 16'd1) begin
            idx_d = 16'd0;
            enter = 1'b1;
          end else begin
            idx_d = idx_inc;
          end
        end
      end
      RUN: begin
        // cnt_q counts down the enable cycles still owed, including this one.
        if (cnt_q <= 32'd1) begin
          enter  = 1'b1;
          rc_sel = 32'd0;
        end else begin
          cpu_en_d = 1'b1;
          cnt_d    = cnt_q - 32'd1;
        end
      end
      DUMP_RD: begin
        state_d = DUMP_CAP;
      end
      DUMP_CAP: begin
        m_data_d  = rdata_ext_2;
        m_valid_d = 1'b1;
        state_d   = DUMP_OUT;
      end
      DUMP_OUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          if (idx_q == dl_q - 16'd1) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            ren2_d  = 1'b1;
            addr2_d = 64'(idx_inc) << 3;
            state_d = DUMP_RD;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs of the entered phase are registered, so they are set up here on
    // the transition; the index is always zero on these paths.
    if (enter) begin
      if (rc_sel != 32'd0) begin
        state_d  = RUN;
        cpu_en_d = 1'b1;
        cnt_d    = rc_sel;
      end else if (dl_sel != 16'd0) begin
        state_d = DUMP_RD;
        ren2_d  = 1'b1;
        addr2_d = 64'd0;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      idx_q     <= 16'd0;
      pl_q      <= 16'd0;
      rc_q      <= 32'd0;
      dl_q      <= 16'd0;
      cnt_q     <= 32'd0;
      cpu_en_q  <= 1'b0;
      addr_q    <= 64'd0;
      wen_q     <= 1'b0;
      wdata_q   <= 32'd0;
      addr2_q   <= 64'd0;
      ren2_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= 64'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pl_q      <= pl_d;
      rc_q      <= rc_d;
      dl_q      <= dl_d;
      cnt_q     <= cnt_d;
      cpu_en_q  <= cpu_en_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      addr2_q   <= addr2_d;
      ren2_q    <= ren2_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign s_ready     = (state_q == LOAD);
  assign busy        = (state_q == LOAD) || (state_q == RUN) || (state_q == DUMP_RD) ||
                       (state_q == DUMP_CAP) || (state_q == DUMP_OUT);
  assign cpu_enable  = cpu_en_q;
  assign addr_ext    = addr_q;
  assign wen_ext     = wen_q;
  assign ren_ext     = 1'b0;
  assign wdata_ext   = wdata_q;
  assign addr_ext_2  = addr2_q;
  assign wen_ext_2   = 1'b0;
  assign ren_ext_2   = ren2_q;
  assign wdata_ext_2 = 64'd0;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign done        = done_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_ext_sequencer.sv
// Testbench for mem_ext_sequencer: table of job vectors driven through one
// generic sequence task, a negedge monitor with expected queues for imem
// writes, dmem reads and dump words, plus hand-written reset sequences.
module tb_mem_ext_sequencer;

  logic        clk;
  logic        arst;
  logic        start;
  logic [15:0] prog_len;
  logic [31:0] run_cycles;
  logic [15:0] dump_len;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        cpu_enable;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic        ren_ext;
  logic [31:0] wdata_ext;
  logic [63:0] addr_ext_2;
  logic        wen_ext_2;
  logic        ren_ext_2;
  logic [63:0] wdata_ext_2;
  logic [63:0] rdata_ext_2;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  dbg_state;

  mem_ext_sequencer #(.IMEM_DEPTH(128), .DMEM_DEPTH(128)) dut (
    .clk(clk), .arst(arst), .start(start), .prog_len(prog_len),
    .run_cycles(run_cycles), .dump_len(dump_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cpu_enable(cpu_enable), .addr_ext(addr_ext), .wen_ext(wen_ext),
    .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .done(done), .error(error), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [95:0] exp_wr_q[$];   // {addr, data}
  logic [63:0] exp_rd_q[$];
  logic [63:0] exp_m_q[$];
  logic        mon_en = 1'b0;
  int          cpu_cnt, cpu_runs;
  logic        cpu_prev, m_hold;
  logic [63:0] m_prev;
  logic        ren_seen = 1'b0;
  logic [63:0] addr_seen = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] prog_word(input int i);
    case (i)
      0: prog_word = 32'h0000_0013;
      1: prog_word = 32'h0010_0093;
      2: prog_word = 32'h0020_8113;
      default: prog_word = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endcase
  endfunction

  function automatic logic [63:0] dmem_word(input logic [63:0] a);
    dmem_word = {32'hD00D_0000 ^ a[31:0], ~a[31:0]};
  endfunction

  // dmem responder: data for the address read in one cycle appears in the next.
  initial begin
    rdata_ext_2 = 64'hBAD0_BAD0_BAD0_BAD0;
    forever begin
      @(posedge clk);
      #1;
      rdata_ext_2 = ren_seen ? dmem_word(addr_seen) : 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ren_seen  = ren_ext_2;
    addr_seen = addr_ext_2;
    if (mon_en) begin
      if (wen_ext) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", 64'(wen_ext), 64'd0);
        else begin
          logic [95:0] e;
          e = exp_wr_q.pop_front();
          chk("wr_addr", addr_ext, e[95:32]);
          chk("wr_data", 64'(wdata_ext), 64'(e[31:0]));
        end
      end
      if (cpu_enable) begin
        cpu_cnt++;
        if (!cpu_prev) cpu_runs++;
      end
      cpu_prev = cpu_enable;
      if (ren_ext_2) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", 64'(ren_ext_2), 64'd0);
        else chk("rd_addr", addr_ext_2, exp_rd_q.pop_front());
      end
      if (m_valid) begin
        if (m_hold) chk("m_stable", m_data, m_prev);
        if (m_ready) begin
          if (exp_m_q.size() == 0) chk("m_unexpected", 64'(m_valid), 64'd0);
          else chk("m_data", m_data, exp_m_q.pop_front());
          m_hold = 1'b0;
        end else begin
          m_hold = 1'b1;
        end
        m_prev = m_data;
      end else begin
        m_hold = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [15:0] pl;
    logic [31:0] rc;
    logic [15:0] dl;
    logic        gap;      // s_valid only every other cycle
    int          stall;    // cycles m_ready stays low per dump word
    int          poke;     // if >0: pulse start / change prog_len after this many words
    logic        exp_err;
    int          lat_max;  // if >0: done must appear within this many cycles of start
  } vec_t;

  task automatic run_seq(input string tag, input vec_t v);
    int sent, stall, lat;
    logic ok, poked;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_m_q.delete();
    if (!v.exp_err) begin
      for (int i = 0; i < int'(v.pl); i++) exp_wr_q.push_back({64'(i) * 64'd4, prog_word(i)});
      for (int j = 0; j < int'(v.dl); j++) begin
        exp_rd_q.push_back(64'(j) * 64'd8);
        exp_m_q.push_back(dmem_word(64'(j) * 64'd8));
      end
    end
    cpu_cnt = 0; cpu_runs = 0; cpu_prev = 1'b0; m_hold = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b1; prog_len = v.pl; run_cycles = v.rc; dump_len = v.dl;
    @(posedge clk); #2;
    start = 1'b0;
    sent = 0; stall = 0; lat = 0; ok = 1'b0; poked = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_valid = (sent < int'(v.pl)) && (!v.gap || cyc[0]);
      s_data  = s_valid ? prog_word(sent) : (32'hBAD0_0000 | 32'(cyc));
      m_ready = (stall >= v.stall);
      if (v.poke > 0 && sent == v.poke && !poked) begin
        start = 1'b1; prog_len = 16'd1; run_cycles = 32'd77; dump_len = 16'd0;
        poked = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) stall = 0;
      else if (m_valid) stall++;
      @(posedge clk); #2;
    end
    s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
    chk({tag, "_done_seen"}, 64'(ok), 64'd1);
    if (v.lat_max > 0) chk({tag, "_done_latency_ok"}, 64'(lat <= v.lat_max), 64'd1);
    @(posedge clk); #1;
    chk({tag, "_error"}, 64'(error), 64'(v.exp_err));
    chk({tag, "_done_held"}, 64'(done), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_cpu_cycles"}, 64'(cpu_cnt), v.exp_err ? 64'd0 : 64'(v.rc));
    chk({tag, "_cpu_runs"}, 64'(cpu_runs), (v.exp_err || v.rc == 0) ? 64'd0 : 64'd1);
    chk({tag, "_wr_left"}, 64'(exp_wr_q.size()), 64'd0);
    chk({tag, "_rd_left"}, 64'(exp_rd_q.size()), 64'd0);
    chk({tag, "_m_left"}, 64'(exp_m_q.size()), 64'd0);
    chk({tag, "_tieoffs"}, {62'd0, ren_ext, wen_ext_2} | wdata_ext_2, 64'd0);
    mon_en = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];
  int   seen;

  initial begin
    arst = 1'b1; start = 1'b0; prog_len = 16'd0; run_cycles = 32'd0; dump_len = 16'd0;
    s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;

    //           pl      rc     dl      gap   stall poke err   lat
    vecs[0] = '{16'd3,   32'd5, 16'd2,   1'b0, 0,    0,   1'b0, 0};
    vecs[1] = '{16'd5,   32'd3, 16'd3,   1'b1, 4,    0,   1'b0, 0};
    vecs[2] = '{16'd129, 32'd5, 16'd2,   1'b0, 0,    0,   1'b1, 1};
    vecs[3] = '{16'd2,   32'd1, 16'd129, 1'b0, 0,    0,   1'b1, 1};
    vecs[4] = '{16'd0,   32'd0, 16'd0,   1'b0, 0,    0,   1'b0, 2};
    vecs[5] = '{16'd4,   32'd2, 16'd1,   1'b0, 0,    2,   1'b0, 0};
    vecs[6] = '{16'd128, 32'd1, 16'd128, 1'b0, 0,    0,   1'b0, 0};
    vecs[7] = '{16'd0,   32'd4, 16'd0,   1'b0, 0,    0,   1'b0, 0};
    vecs[8] = '{16'd0,   32'd0, 16'd2,   1'b0, 1,    0,   1'b0, 0};
    vecs[9] = '{16'd2,   32'd0, 16'd0,   1'b1, 0,    0,   1'b0, 0};

    #3;
    chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("rst_wen_ext", 64'(wen_ext), 64'd0);
    chk("rst_ren_ext_2", 64'(ren_ext_2), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_addr_ext", addr_ext, 64'd0);
    chk("rst_addr_ext_2", addr_ext_2, 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    arst = 1'b0;

    for (int k = 0; k < 10; k++) run_seq($sformatf("vec%0d", k), vecs[k]);

    // Reset in the third of ten RUN cycles, then a full job must still work.
    @(posedge clk); #2;
    start = 1'b1; prog_len = 16'd0; run_cycles = 32'd10; dump_len = 16'd1;
    @(posedge clk); #2;
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && seen < 3; c++) begin
      @(negedge clk);
      if (cpu_enable) seen++;
    end
    chk("midrun_cpu_seen", 64'(seen), 64'd3);
    #2 arst = 1'b1;
    #1;
    chk("midrun_rst_cpu_enable", 64'(cpu_enable), 64'd0);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_done", 64'(done), 64'd0);
    chk("midrun_rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk); #1;
    chk("midrun_hold_cpu_enable", 64'(cpu_enable), 64'd0);
    @(negedge clk);
    arst = 1'b0;
    run_seq("after_rst", vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
